// File: rtl/div_seq_ctrl_if.sv
`timescale 1ns/1ps
// div_seq_ctrl_if: request/response handshake, pipeline stall and divider
// launch/result signals between the execute stage, the shared iterative
// divider and the division sequencer.
//   slave  : view of the sequencer (serves requests, launches the divider)
//   master : view of the surroundings (execute stage plus divider)
interface div_seq_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            stall;
  logic            div_start;
  logic [XLEN-1:0] div_x;
  logic [XLEN-1:0] div_y;
  logic            div_busy;
  logic            div_done;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] div_r;
  logic            div_dbz;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    input  div_busy, div_done, div_q, div_r, div_dbz,
    output req_ready, rsp_valid, rsp_data, stall,
    output div_start, div_x, div_y
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    output div_busy, div_done, div_q, div_r, div_dbz,
    input  req_ready, rsp_valid, rsp_data, stall,
    input  div_start, div_x, div_y
  );
endinterface

// File: rtl/div_seq_ctrl.sv
`timescale 1ns/1ps
// div_seq_ctrl: sequencer between the execute stage and the shared iterative
// unsigned divider for RISC-V DIV/DIVU/REM/REMU. Signed operands are converted
// to magnitudes, divide-by-zero and signed overflow are answered without the
// divider, and the divider result is sign-corrected before being returned.
// Optional feature macro DIV_REM_FUSE_EN: remembers the last divided operand
// pair so the quotient/remainder partner request is answered without the
// divider.
module div_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  div_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    FIX    = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Two's-complement negate; the most negative value maps onto itself.
  function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] v);
    return ~v + ONE;
  endfunction

  state_t          state_r;
  logic            rdy_en_r;
  logic            rsp_valid_r;
  logic            stall_r;
  logic            div_start_r;
  logic            rem_r;
  logic            neg_a_r;
  logic            neg_b_r;
  logic [XLEN-1:0] rsp_data_r;
  logic [XLEN-1:0] div_x_r;
  logic [XLEN-1:0] div_y_r;
  logic [XLEN-1:0] q_raw_r;
  logic [XLEN-1:0] r_raw_r;

  logic            req_ready_s;
  logic            signed_s;
  logic            rem_s;
  logic            neg_a_s;
  logic            neg_b_s;
  logic            dbz_s;
  logic            ovf_s;
  logic            fuse_hit_s;
  logic [XLEN-1:0] abs_a_s;
  logic [XLEN-1:0] abs_b_s;
  logic [XLEN-1:0] spec_data_s;
  logic [XLEN-1:0] fuse_data_s;
  logic [XLEN-1:0] fix_q_s;
  logic [XLEN-1:0] fix_r_s;

`ifdef DIV_REM_FUSE_EN
  logic            signed_r;
  logic [XLEN-1:0] a_r;
  logic [XLEN-1:0] b_r;
  logic            tag_valid_r;
  logic            tag_signed_r;
  logic            tag_rem_r;
  logic [XLEN-1:0] tag_a_r;
  logic [XLEN-1:0] tag_b_r;
  logic [XLEN-1:0] tag_q_r;
  logic [XLEN-1:0] tag_r_r;
`endif

  // Ready only in IDLE (registered enable) and only while the shared divider is free.
  assign req_ready_s   = rdy_en_r & ~bus.div_busy;
  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.stall     = stall_r;
  assign bus.div_start = div_start_r;
  assign bus.div_x     = div_x_r;
  assign bus.div_y     = div_y_r;

  // Request decode (signs, magnitudes, special cases) and result sign fix-up.
  always_comb begin
    signed_s    = ~bus.req_op[0];
    rem_s       = bus.req_op[1];
    neg_a_s     = signed_s & bus.req_a[XLEN-1];
    neg_b_s     = signed_s & bus.req_b[XLEN-1];
    abs_a_s     = neg_a_s ? neg_f(bus.req_a) : bus.req_a;
    abs_b_s     = neg_b_s ? neg_f(bus.req_b) : bus.req_b;
    dbz_s       = (bus.req_b == ZERO);
    ovf_s       = signed_s && (bus.req_a == MIN_NEG) && (bus.req_b == ONES);
    spec_data_s = ZERO;
    if (dbz_s) begin
      spec_data_s = rem_s ? bus.req_a : ONES;
    end else if (ovf_s) begin
      spec_data_s = rem_s ? ZERO : bus.req_a;
    end else begin
      spec_data_s = ZERO;
    end
`ifdef DIV_REM_FUSE_EN
    fuse_hit_s  = tag_valid_r && (bus.req_a == tag_a_r) && (bus.req_b == tag_b_r) &&
                  (signed_s == tag_signed_r) && (rem_s != tag_rem_r);
    fuse_data_s = rem_s ? tag_r_r : tag_q_r;
`else
    fuse_hit_s  = 1'b0;
    fuse_data_s = ZERO;
`endif
    // Sign flags are zero for unsigned ops, so DIVU/REMU pass through raw.
    fix_q_s     = (neg_a_r ^ neg_b_r) ? neg_f(q_raw_r) : q_raw_r;
    fix_r_s     = neg_a_r ? neg_f(r_raw_r) : r_raw_r;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      rdy_en_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= ZERO;
      stall_r     <= 1'b0;
      div_start_r <= 1'b0;
      div_x_r     <= ZERO;
      div_y_r     <= ZERO;
      rem_r       <= 1'b0;
      neg_a_r     <= 1'b0;
      neg_b_r     <= 1'b0;
      q_raw_r     <= ZERO;
      r_raw_r     <= ZERO;
`ifdef DIV_REM_FUSE_EN
      signed_r     <= 1'b0;
      a_r          <= ZERO;
      b_r          <= ZERO;
      tag_valid_r  <= 1'b0;
      tag_signed_r <= 1'b0;
      tag_rem_r    <= 1'b0;
      tag_a_r      <= ZERO;
      tag_b_r      <= ZERO;
      tag_q_r      <= ZERO;
      tag_r_r      <= ZERO;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid && req_ready_s) begin
            rdy_en_r <= 1'b0;
            stall_r  <= 1'b1;
            rem_r    <= rem_s;
            neg_a_r  <= neg_a_s;
            neg_b_r  <= neg_b_s;
`ifdef DIV_REM_FUSE_EN
            signed_r <= signed_s;
            a_r      <= bus.req_a;
            b_r      <= bus.req_b;
`endif
            if (dbz_s || ovf_s) begin
              rsp_data_r  <= spec_data_s;
              rsp_valid_r <= 1'b1;
              state_r     <= RESP;
`ifdef DIV_REM_FUSE_EN
              tag_valid_r <= 1'b0;
`endif
            end else if (fuse_hit_s) begin
              rsp_data_r  <= fuse_data_s;
              rsp_valid_r <= 1'b1;
              state_r     <= RESP;
            end else begin
              div_x_r     <= abs_a_s;
              div_y_r     <= abs_b_s;
              div_start_r <= 1'b1;
              state_r     <= LAUNCH;
            end
          end else begin
            rdy_en_r <= 1'b1;
          end
        end
        LAUNCH: begin
          div_start_r <= 1'b0;
          state_r     <= WAIT;
        end
        WAIT: begin
          if (bus.div_done && !bus.div_busy) begin
            q_raw_r <= bus.div_q;
            r_raw_r <= bus.div_r;
            state_r <= FIX;
          end
        end
        FIX: begin
          rsp_data_r  <= rem_r ? fix_r_s : fix_q_s;
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
`ifdef DIV_REM_FUSE_EN
          tag_valid_r  <= 1'b1;
          tag_signed_r <= signed_r;
          tag_rem_r    <= rem_r;
          tag_a_r      <= a_r;
          tag_b_r      <= b_r;
          tag_q_r      <= fix_q_s;
          tag_r_r      <= fix_r_s;
`endif
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            stall_r     <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          rdy_en_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
          stall_r     <= 1'b0;
          div_start_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
`timescale 1ns/1ps
// tb_div_seq_ctrl: directed and randomized checks of div_seq_ctrl against an
// arithmetic reference of RISC-V division, with a behavioural divider model.
module tb_div_seq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  div_seq_ctrl_if #(.XLEN(32)) bus ();

  div_seq_ctrl #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural shared divider: variable latency, busy while iterating.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        busy_force = 1'b0;
  logic [31:0] lx = 32'd0, ly = 32'd0, m_q = 32'd0, m_r = 32'd0;
  int          m_cnt = 0;

  assign bus.div_busy = m_busy | busy_force;
  assign bus.div_done = m_done;
  assign bus.div_q    = m_q;
  assign bus.div_r    = m_r;
  assign bus.div_dbz  = 1'b0;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (bus.div_start) begin
      lx     <= bus.div_x;
      ly     <= bus.div_y;
      m_cnt  <= $urandom_range(2, 6);
      m_busy <= 1'b1;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_q    <= (ly == 32'd0) ? 32'hFFFF_FFFF : lx / ly;
        m_r    <= (ly == 32'd0) ? lx : lx % ly;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch monitor: counts div_start cycles and checks the operand magnitudes.
  int          start_cnt = 0;
  logic [31:0] exp_x = 32'd0, exp_y = 32'd0;
  always @(negedge clk) begin
    if (bus.div_start === 1'b1) begin
      start_cnt++;
      check("div_x", bus.div_x, exp_x);
      check("div_y", bus.div_y, exp_y);
    end
  end

  // Architectural result of a RISC-V M-extension division.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0:    return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      2'd1:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  // Model of the remembered operand pair (meaningful only with fusion enabled).
  bit          t_valid = 1'b0;
  bit          t_signed = 1'b0;
  bit          t_rem = 1'b0;
  logic [31:0] t_a = 32'd0, t_b = 32'd0;
  int          starts0 = 0;

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 32'(n < 200), 32'd1);
    exp_x = (!op[0] && a[31]) ? 32'd0 - a : a;
    exp_y = (!op[0] && b[31]) ? 32'd0 - b : b;
    starts0 = start_cnt;
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a = $urandom;
    bus.req_b = $urandom;
  endtask

  task automatic collect(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp_d;
    bit          spec, hit;
    int          lat;
    exp_d = ref_res(op, a, b);
    spec  = is_special(op, a, b);
`ifdef DIV_REM_FUSE_EN
    hit = t_valid && (a == t_a) && (b == t_b) && (t_signed == !op[0]) && (t_rem != op[1]);
`else
    hit = 1'b0;
`endif
    @(negedge clk);
    lat = 1;
    check("stall_after_accept", 32'(bus.stall), 32'd1);
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);
    while (bus.rsp_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_valid_timeout", 32'(bus.rsp_valid), 32'd1);
    check("rsp_data", bus.rsp_data, exp_d);
    if (spec || hit) check("latency_short", 32'(lat), 32'd1);
    else             check("latency_divider", 32'(lat >= 3), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_data", bus.rsp_data, exp_d);
      check("hold_stall", 32'(bus.stall), 32'd1);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    check("stall_drop", 32'(bus.stall), 32'd0);
    check("div_start_count", 32'(start_cnt - starts0), (spec || hit) ? 32'd0 : 32'd1);
    if (spec) begin
      t_valid = 1'b0;
    end else if (!hit) begin
      t_valid  = 1'b1;
      t_a      = a;
      t_b      = b;
      t_signed = !op[0];
      t_rem    = op[1];
    end
  endtask

  task automatic txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    send(op, a, b);
    collect(op, a, b, hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          n;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_div_start", 32'(bus.div_start), 32'd0);
    check("rst_div_x", bus.div_x, 32'd0);
    check("rst_div_y", bus.div_y, 32'd0);
    reset = 1'b0;

    // Signed sign fix-up, divide-by-zero, overflow, back-pressure.
    txn(2'd0, 32'hFFFF_FFF9, 32'd2, 0);
    txn(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    txn(2'd1, 32'd5, 32'd0, 0);
    txn(2'd3, 32'd5, 32'd0, 0);
    txn(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    txn(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    txn(2'd1, 32'd100, 32'd7, 5);

    // Reset while the divider is iterating.
    send(2'd1, 32'd1000, 32'd3);
    @(negedge clk);
    @(negedge clk);
    busy_force = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    t_valid = 1'b0;
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_stall", 32'(bus.stall), 32'd0);
    check("midrst_div_start", 32'(bus.div_start), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    end
    busy_force = 1'b0;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_after_busy", 32'(bus.req_ready), 32'd1);
    txn(2'd1, 32'd9, 32'd3, 0);

    // Quotient followed by its remainder partner.
    txn(2'd0, 32'd20, 32'd6, 0);
    txn(2'd2, 32'd20, 32'd6, 0);

    // Randomized operands, biased towards the corner values.
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = 32'h8000_0000;
        2:       a = 32'($urandom_range(0, 50));
        default: a = 32'd0 - 32'($urandom_range(1, 50));
      endcase
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = 32'd0;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 20));
        default: b = 32'd0 - 32'($urandom_range(1, 20));
      endcase
      txn(op, a, b, $urandom_range(0, 3));
      if (($urandom_range(0, 3) == 0) && !is_special(op, a, b)) begin
        op[1] = ~op[1];
        txn(op, a, b, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencer between the core execute stage and the shared iterative unsigned divider.
- Accepts RISC-V M-extension DIV/DIVU/REM/REMU requests and handles operand sign conversion.
- Resolves divide-by-zero and signed overflow directly, without running the divider.
- Launches and monitors the divider, applies sign fix-up, and returns one XLEN result over a valid/ready handshake; drives the pipeline stall.

Parameters:
XLEN, 32, operand/result width; must equal the divider WIDTH.

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
req_a  in  XLEN  dividend (rs1)
req_b  in  XLEN  divisor (rs2)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_data  out  XLEN  result
stall  out  1  high from acceptance until response handshake
div_start  out  1  one-cycle divider launch pulse
div_x  out  XLEN  unsigned dividend to divider
div_y  out  XLEN  unsigned divisor to divider
div_busy  in  1  divider iterating
div_done  in  1  divider finished
div_q  in  XLEN  unsigned quotient
div_r  in  XLEN  unsigned remainder
div_dbz  in  1  divider divide-by-zero flag (ignored; zero is pre-filtered)

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, stall=0, div_start=0, div_x=0, div_y=0; state=IDLE; fuse tag invalid.
- State machine: IDLE, LAUNCH, WAIT, FIX, RESP.
- IDLE:
  - req_ready = !div_busy.
  - A request is accepted on req_valid && req_ready. At acceptance the controller latches op, sign flags and absolute operands, and stall rises next cycle.
- Signed ops (DIV, REM): neg_a = a[XLEN-1], neg_b = b[XLEN-1]. div_x = |a|, div_y = |b|; two's-complement negate, so |0x80..0| = 0x80..0 unsigned.
- Unsigned ops: div_x = a, div_y = b.
- Special cases go IDLE->RESP with no div_start; rsp_data is valid the cycle after acceptance.
  - b==0: quotient = all ones; remainder = a.
  - Signed op with a==0x80..0 and b==all ones: DIV gives a; REM gives 0.
- LAUNCH: exactly one cycle. div_start=1 and div_x/div_y are driven. div_x/div_y are held stable until WAIT exits. Next state is WAIT.
- WAIT: exit to FIX on the first cycle where div_done && !div_busy. There is no timeout.
- FIX (one cycle) registers rsp_data:
  - DIV: neg_a^neg_b ? -div_q : div_q.
  - REM: neg_a ? -div_r : div_r.
  - DIVU/REMU: raw div_q / div_r.
- RESP:
  - rsp_valid=1; rsp_data is held stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE; stall falls the same edge.
  - req_ready stays 0 in RESP, so there is no accept in the same cycle as the response.
- Normal latency: acceptance edge + 1 (LAUNCH) + divider cycles + 1 (FIX) -> rsp_valid.
- Reset mid-operation:
  - Return to IDLE and drop rsp_valid, stall and div_start.
  - The in-flight divider result is discarded.
  - req_ready stays 0 until div_busy is low.
- req_* are ignored outside IDLE.

Optional Feature:
- Macro DIV_REM_FUSE_EN.
- When defined, FIX also stores {a, b, signedness, final quotient, final remainder} as a valid fuse tag.
- A later request whose operands and signedness match the tag, but whose op is the quotient/remainder partner, skips the divider: IDLE->RESP with the stored value, rsp_valid the cycle after acceptance.
- The tag is invalidated by reset and by any special-case request.
- When undefined, there is no tag storage and every non-special request runs the divider.

Test Plan:
- DIV a=0xFFFFFFF9 (-7), b=2 -> single div_start with div_x=7, div_y=2; rsp_data=0xFFFFFFFD. Repeat as REM -> 0xFFFFFFFF.
- DIVU a=5, b=0 -> no div_start, rsp_data=0xFFFFFFFF one cycle after accept. REMU a=5, b=0 -> rsp_data=5.
- DIV a=0x80000000, b=0xFFFFFFFF -> rsp_data=0x80000000, no div_start. REM with same operands -> 0x00000000.
- DIVU a=100, b=7 with rsp_ready held low 5 cycles -> rsp_valid and rsp_data=14 stable throughout; stall stays high; req_ready=0 until handshake.
- Assert reset during WAIT with div_busy=1 -> rsp_valid=0, stall=0 next cycle; req_ready=0 until div_busy falls; next DIVU 9/3 returns 3.
- With DIV_REM_FUSE_EN: DIV 20/6 (=3), then REM 20/6 -> second response 2, no second div_start, latency 1 cycle. Without the macro, the second div_start occurs.
